// File: rtl/blc_pkg.sv
// Shared definitions for the black-level offset estimator.
// Optional IIR smoothing of successive offsets is enabled by defining BLC_EST_IIR_EN.
package blc_pkg;

  // Estimator states: gathering samples, or presenting a finished offset.
  typedef enum logic {
    ACCUM  = 1'b0,
    OUTPUT = 1'b1
  } blc_state_e;

  // Lane positions of each colour inside the packed {R,G,B} buses.
  localparam int CH_R = 2;
  localparam int CH_G = 1;
  localparam int CH_B = 0;

  // Width needed to sum 2^log2_n samples of dw bits without overflow.
  function automatic int acc_width(input int dw, input int log2_n);
    return dw + log2_n;
  endfunction

endpackage

// File: rtl/blc_acc_ch.sv
// One colour channel of the black-level estimator: accumulates a window of
// samples, derives the floor mean, clips it and registers the offset.
// With BLC_EST_IIR_EN defined, each window after the first is averaged
// (rounding up) with the previous offset.
module blc_acc_ch
  import blc_pkg::*;
#(
  parameter int DATA_WIDTH = 12,
  parameter int LOG2_N     = 6,
  parameter int MAX_OFFSET = 1023
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  clear,
  input  logic                  add_i,
  input  logic                  last_i,
  input  logic [DATA_WIDTH-1:0] sample_i,
  output logic [DATA_WIDTH-1:0] offset_o
);

  localparam int ACC_W = acc_width(DATA_WIDTH, LOG2_N);
  localparam logic [DATA_WIDTH-1:0] MAX_V = DATA_WIDTH'(MAX_OFFSET);

  logic [ACC_W-1:0]      acc_q;
  logic [ACC_W-1:0]      sum;
  logic [DATA_WIDTH-1:0] mean;
  logic [DATA_WIDTH-1:0] clip_v;
  logic [DATA_WIDTH-1:0] offset_q;
  logic [DATA_WIDTH-1:0] offset_d;

`ifdef BLC_EST_IIR_EN
  logic                  hist_valid_q;
  logic [DATA_WIDTH:0]   blend_sum;
`endif

  // Running sum including the current sample, its floor mean and the clip.
  always_comb begin
    sum    = acc_q + ACC_W'(sample_i);
    mean   = DATA_WIDTH'(sum >> LOG2_N);
    clip_v = (mean > MAX_V) ? MAX_V : mean;
`ifdef BLC_EST_IIR_EN
    blend_sum = {1'b0, offset_q} + {1'b0, clip_v} + (DATA_WIDTH+1)'(1);
    offset_d  = hist_valid_q ? DATA_WIDTH'(blend_sum >> 1) : clip_v;
`else
    offset_d  = clip_v;
`endif
  end

  // Accumulator and offset register; clear restarts the window but keeps the offset.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      acc_q    <= '0;
      offset_q <= '0;
    end else if (clear) begin
      acc_q    <= '0;
    end else if (add_i) begin
      if (last_i) begin
        acc_q    <= '0;
        offset_q <= offset_d;
      end else begin
        acc_q    <= sum;
      end
    end
  end

`ifdef BLC_EST_IIR_EN
  // History is valid once a window has completed since the last reset or clear.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      hist_valid_q <= 1'b0;
    end else if (clear) begin
      hist_valid_q <= 1'b0;
    end else if (add_i && last_i) begin
      hist_valid_q <= 1'b1;
    end
  end
`endif

  assign offset_o = offset_q;

endmodule

// File: rtl/blc_offset_est.sv
// Black-level offset estimator top: per-window {R,G,B} mean of optical-black
// samples feeding the BLC correction chain. Owns the ACCUM/OUTPUT FSM, the
// sample counter and the ready handshake. Optional feature macro: BLC_EST_IIR_EN.
module blc_offset_est
  import blc_pkg::*;
#(
  parameter int DATA_WIDTH = 12,
  parameter int LOG2_N     = 6,
  parameter int MAX_OFFSET = 1023
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    clear,
  input  logic                    u_i_ready,
  input  logic                    u_r_ready,
  input  logic [3*DATA_WIDTH-1:0] data_in,
  output logic [3*DATA_WIDTH-1:0] offset_out,
  output logic                    i_i_ready,
  output logic                    i_r_ready,
  output logic [LOG2_N-1:0]       sample_cnt
);

  localparam logic [LOG2_N-1:0] CNT_LAST = '1;

  blc_state_e        state_q;
  blc_state_e        state_d;
  logic [LOG2_N-1:0] cnt_q;
  logic              accept;
  logic              last;

  assign i_i_ready  = (state_q == ACCUM);
  assign i_r_ready  = (state_q == OUTPUT);
  assign sample_cnt = cnt_q;
  assign accept     = u_i_ready && i_i_ready;
  assign last       = accept && (cnt_q == CNT_LAST);

  // Next state: window completion moves to OUTPUT, removal or clear returns to ACCUM.
  always_comb begin
    state_d = state_q;
    if (clear) begin
      state_d = ACCUM;
    end else begin
      case (state_q)
        ACCUM:   if (last)      state_d = OUTPUT;
        OUTPUT:  if (u_r_ready) state_d = ACCUM;
        default: state_d = ACCUM;
      endcase
    end
  end

  // State register.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state_q <= ACCUM;
    else        state_q <= state_d;
  end

  // Sample counter; wraps to zero naturally on the final sample of a window.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset)      cnt_q <= '0;
    else if (clear)  cnt_q <= '0;
    else if (accept) cnt_q <= cnt_q + LOG2_N'(1);
  end

  blc_acc_ch #(.DATA_WIDTH(DATA_WIDTH), .LOG2_N(LOG2_N), .MAX_OFFSET(MAX_OFFSET)) u_ch_r (
    .clock    (clock),
    .reset    (reset),
    .clear    (clear),
    .add_i    (accept),
    .last_i   (last),
    .sample_i (data_in[CH_R*DATA_WIDTH +: DATA_WIDTH]),
    .offset_o (offset_out[CH_R*DATA_WIDTH +: DATA_WIDTH])
  );

  blc_acc_ch #(.DATA_WIDTH(DATA_WIDTH), .LOG2_N(LOG2_N), .MAX_OFFSET(MAX_OFFSET)) u_ch_g (
    .clock    (clock),
    .reset    (reset),
    .clear    (clear),
    .add_i    (accept),
    .last_i   (last),
    .sample_i (data_in[CH_G*DATA_WIDTH +: DATA_WIDTH]),
    .offset_o (offset_out[CH_G*DATA_WIDTH +: DATA_WIDTH])
  );

  blc_acc_ch #(.DATA_WIDTH(DATA_WIDTH), .LOG2_N(LOG2_N), .MAX_OFFSET(MAX_OFFSET)) u_ch_b (
    .clock    (clock),
    .reset    (reset),
    .clear    (clear),
    .add_i    (accept),
    .last_i   (last),
    .sample_i (data_in[CH_B*DATA_WIDTH +: DATA_WIDTH]),
    .offset_o (offset_out[CH_B*DATA_WIDTH +: DATA_WIDTH])
  );

endmodule

// File: tb/tb_blc_offset_est.sv
// Directed bench for blc_offset_est with DATA_WIDTH=12, LOG2_N=2 (N=4),
// MAX_OFFSET=1023. Window-blending checks are included when BLC_EST_IIR_EN is defined.
module tb_blc_offset_est;

  localparam int DW = 12;
  localparam int L2 = 2;

  logic          clock;
  logic          reset;
  logic          clear;
  logic          u_i_ready;
  logic          u_r_ready;
  logic [3*DW-1:0] data_in;
  logic [3*DW-1:0] offset_out;
  logic          i_i_ready;
  logic          i_r_ready;
  logic [L2-1:0] sample_cnt;

  int n_cmp = 0;
  int n_err = 0;

  blc_offset_est #(.DATA_WIDTH(DW), .LOG2_N(L2), .MAX_OFFSET(1023)) dut (
    .clock      (clock),
    .reset      (reset),
    .clear      (clear),
    .u_i_ready  (u_i_ready),
    .u_r_ready  (u_r_ready),
    .data_in    (data_in),
    .offset_out (offset_out),
    .i_i_ready  (i_i_ready),
    .i_r_ready  (i_r_ready),
    .sample_cnt (sample_cnt)
  );

  // Free-running clock, rising edges at 5, 15, 25 ...
  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Present one sample for a single edge.
  task automatic push(input logic [DW-1:0] r, input logic [DW-1:0] g, input logic [DW-1:0] b);
    u_i_ready = 1'b1;
    data_in   = {r, g, b};
    tick();
    u_i_ready = 1'b0;
  endtask

  // Downstream takes the offset on one edge.
  task automatic pop();
    u_r_ready = 1'b1;
    tick();
    u_r_ready = 1'b0;
  endtask

  // One-edge clear pulse.
  task automatic pulse_clear();
    clear = 1'b1;
    tick();
    clear = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0; clear = 1'b0; u_i_ready = 1'b0; u_r_ready = 1'b0; data_in = '0;
    #2;
    n_cmp++; if (i_i_ready !== 1'b1) begin n_err++; $display("[TB] FAIL reset_iir: got %b want 1", i_i_ready); end
    n_cmp++; if (i_r_ready !== 1'b0) begin n_err++; $display("[TB] FAIL reset_irr: got %b want 0", i_r_ready); end
    n_cmp++; if (offset_out !== '0) begin n_err++; $display("[TB] FAIL reset_off: got %h want 0", offset_out); end
    n_cmp++; if (sample_cnt !== '0) begin n_err++; $display("[TB] FAIL reset_cnt: got %0d want 0", sample_cnt); end
    tick();
    reset = 1'b1;
    tick();
  endtask

  task automatic test_basic();
    push(12'd64, 12'd60, 12'd70);
    push(12'd64, 12'd60, 12'd70);
    push(12'd64, 12'd60, 12'd70);
    n_cmp++; if (sample_cnt !== 2'd3) begin n_err++; $display("[TB] FAIL basic_cnt3: got %0d want 3", sample_cnt); end
    n_cmp++; if (i_r_ready !== 1'b0) begin n_err++; $display("[TB] FAIL basic_early: got %b want 0", i_r_ready); end
    push(12'd64, 12'd60, 12'd70);
    n_cmp++; if (i_r_ready !== 1'b1) begin n_err++; $display("[TB] FAIL basic_irr: got %b want 1", i_r_ready); end
    n_cmp++; if (i_i_ready !== 1'b0) begin n_err++; $display("[TB] FAIL basic_iir: got %b want 0", i_i_ready); end
    n_cmp++; if (offset_out !== {12'd64, 12'd60, 12'd70}) begin n_err++; $display("[TB] FAIL basic_off: got %h want %h", offset_out, {12'd64, 12'd60, 12'd70}); end
    n_cmp++; if (sample_cnt !== 2'd0) begin n_err++; $display("[TB] FAIL basic_cnt0: got %0d want 0", sample_cnt); end
    pop();
    n_cmp++; if (i_i_ready !== 1'b1) begin n_err++; $display("[TB] FAIL basic_pop_iir: got %b want 1", i_i_ready); end
    n_cmp++; if (i_r_ready !== 1'b0) begin n_err++; $display("[TB] FAIL basic_pop_irr: got %b want 0", i_r_ready); end
  endtask

  task automatic test_floor();
    pulse_clear();
    push(12'd10, 12'd0, 12'd0);
    push(12'd11, 12'd0, 12'd0);
    push(12'd12, 12'd0, 12'd0);
    push(12'd13, 12'd0, 12'd0);
    n_cmp++; if (offset_out !== {12'd11, 12'd0, 12'd0}) begin n_err++; $display("[TB] FAIL floor_off: got %h want %h", offset_out, {12'd11, 12'd0, 12'd0}); end
    pop();
  endtask

  task automatic test_clip();
    pulse_clear();
    for (int i = 0; i < 4; i++) push(12'd4000, 12'd4000, 12'd4000);
    n_cmp++; if (offset_out !== {12'd1023, 12'd1023, 12'd1023}) begin n_err++; $display("[TB] FAIL clip_off: got %h want %h", offset_out, {12'd1023, 12'd1023, 12'd1023}); end
    pop();
    pulse_clear();
    // Mean exactly at the clip boundary passes through unchanged; one above is clipped.
    push(12'd1023, 12'd1024, 12'd1022);
    push(12'd1023, 12'd1024, 12'd1022);
    push(12'd1023, 12'd1024, 12'd1022);
    push(12'd1023, 12'd1024, 12'd1022);
    n_cmp++; if (offset_out !== {12'd1023, 12'd1023, 12'd1022}) begin n_err++; $display("[TB] FAIL clip_edge: got %h want %h", offset_out, {12'd1023, 12'd1023, 12'd1022}); end
    pop();
  endtask

  task automatic test_backpressure();
    pulse_clear();
    for (int i = 0; i < 4; i++) push(12'd1, 12'd2, 12'd3);
    u_i_ready = 1'b1;
    data_in   = {12'd500, 12'd500, 12'd500};
    for (int i = 0; i < 5; i++) begin
      tick();
      n_cmp++; if (offset_out !== {12'd1, 12'd2, 12'd3}) begin n_err++; $display("[TB] FAIL bp_off[%0d]: got %h want %h", i, offset_out, {12'd1, 12'd2, 12'd3}); end
      n_cmp++; if (sample_cnt !== 2'd0) begin n_err++; $display("[TB] FAIL bp_cnt[%0d]: got %0d want 0", i, sample_cnt); end
      n_cmp++; if (i_r_ready !== 1'b1) begin n_err++; $display("[TB] FAIL bp_irr[%0d]: got %b want 1", i, i_r_ready); end
    end
    u_r_ready = 1'b1;
    tick();
    u_r_ready = 1'b0;
    n_cmp++; if (sample_cnt !== 2'd0) begin n_err++; $display("[TB] FAIL bp_pop_cnt: got %0d want 0", sample_cnt); end
    n_cmp++; if (i_i_ready !== 1'b1) begin n_err++; $display("[TB] FAIL bp_pop_iir: got %b want 1", i_i_ready); end
    tick();
    u_i_ready = 1'b0;
    n_cmp++; if (sample_cnt !== 2'd1) begin n_err++; $display("[TB] FAIL bp_resume_cnt: got %0d want 1", sample_cnt); end
    pulse_clear();
  endtask

  task automatic test_clear();
    push(12'd99, 12'd99, 12'd99);
    push(12'd99, 12'd99, 12'd99);
    pulse_clear();
    n_cmp++; if (sample_cnt !== 2'd0) begin n_err++; $display("[TB] FAIL clr_cnt: got %0d want 0", sample_cnt); end
    for (int i = 0; i < 4; i++) push(12'd20, 12'd20, 12'd20);
    n_cmp++; if (offset_out !== {12'd20, 12'd20, 12'd20}) begin n_err++; $display("[TB] FAIL clr_off: got %h want %h", offset_out, {12'd20, 12'd20, 12'd20}); end
    pop();
    pulse_clear();
    for (int i = 0; i < 3; i++) push(12'd7, 12'd7, 12'd7);
    clear = 1'b1;
    push(12'd7, 12'd7, 12'd7);
    clear = 1'b0;
    n_cmp++; if (i_r_ready !== 1'b0) begin n_err++; $display("[TB] FAIL clr_last_irr: got %b want 0", i_r_ready); end
    n_cmp++; if (sample_cnt !== 2'd0) begin n_err++; $display("[TB] FAIL clr_last_cnt: got %0d want 0", sample_cnt); end
    n_cmp++; if (offset_out !== {12'd20, 12'd20, 12'd20}) begin n_err++; $display("[TB] FAIL clr_last_keep: got %h want %h", offset_out, {12'd20, 12'd20, 12'd20}); end
    for (int i = 0; i < 4; i++) push(12'd8, 12'd16, 12'd4);
    n_cmp++; if (offset_out !== {12'd8, 12'd16, 12'd4}) begin n_err++; $display("[TB] FAIL clr_after: got %h want %h", offset_out, {12'd8, 12'd16, 12'd4}); end
    // Clear together with removal behaves like a plain removal.
    clear = 1'b1;
    pop();
    clear = 1'b0;
    n_cmp++; if (i_i_ready !== 1'b1) begin n_err++; $display("[TB] FAIL clr_pop_iir: got %b want 1", i_i_ready); end
  endtask

  task automatic test_async_reset();
    push(12'd5, 12'd5, 12'd5);
    push(12'd5, 12'd5, 12'd5);
    #2;
    reset = 1'b0;
    #1;
    n_cmp++; if (i_i_ready !== 1'b1) begin n_err++; $display("[TB] FAIL arst_iir: got %b want 1", i_i_ready); end
    n_cmp++; if (i_r_ready !== 1'b0) begin n_err++; $display("[TB] FAIL arst_irr: got %b want 0", i_r_ready); end
    n_cmp++; if (offset_out !== '0) begin n_err++; $display("[TB] FAIL arst_off: got %h want 0", offset_out); end
    n_cmp++; if (sample_cnt !== 2'd0) begin n_err++; $display("[TB] FAIL arst_cnt: got %0d want 0", sample_cnt); end
    tick();
    reset = 1'b1;
    tick();
  endtask

`ifdef BLC_EST_IIR_EN
  task automatic test_iir();
    pulse_clear();
    for (int i = 0; i < 4; i++) push(12'd100, 12'd100, 12'd100);
    n_cmp++; if (offset_out !== {12'd100, 12'd100, 12'd100}) begin n_err++; $display("[TB] FAIL iir_first: got %h want %h", offset_out, {12'd100, 12'd100, 12'd100}); end
    pop();
    for (int i = 0; i < 4; i++) push(12'd50, 12'd50, 12'd50);
    n_cmp++; if (offset_out !== {12'd75, 12'd75, 12'd75}) begin n_err++; $display("[TB] FAIL iir_second: got %h want %h", offset_out, {12'd75, 12'd75, 12'd75}); end
    pop();
    for (int i = 0; i < 4; i++) push(12'd50, 12'd50, 12'd50);
    n_cmp++; if (offset_out !== {12'd63, 12'd63, 12'd63}) begin n_err++; $display("[TB] FAIL iir_third: got %h want %h", offset_out, {12'd63, 12'd63, 12'd63}); end
    pop();
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_floor();
    test_clip();
    test_backpressure();
    test_clear();
    test_async_reset();
`ifdef BLC_EST_IIR_EN
    test_iir();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
